// File: rtl/fifo_flow_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fifo_flow_ctrl_pkg
// Shared defaults for the lane FIFO. The arbiters and the lane-level top use
// these same values, so the sizes are defined in one place.
//   DEF_DATA_W    payload width; the dest field is the top two bits
//   DEF_ADDR_W    address width; depth = 2**DEF_ADDR_W
//   DEF_AF_THRESH almost_full when occupancy >= this value
//   DEF_AE_THRESH almost_empty when occupancy <= this value
// -----------------------------------------------------------------------------
package fifo_flow_ctrl_pkg;

  localparam int DEF_DATA_W    = 6;
  localparam int DEF_ADDR_W    = 2;
  localparam int DEF_AF_THRESH = 3;
  localparam int DEF_AE_THRESH = 1;

endpackage : fifo_flow_ctrl_pkg

// File: rtl/fifo_flow_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_flow_ctrl_if
// Push/pop handshake and status bundle between a transaction-layer arbiter
// and one lane FIFO.
//   master : the arbiter side (drives push, pop, data_in; reads status)
//   slave  : the FIFO side (reads strobes; drives data, flags, count, errors)
// -----------------------------------------------------------------------------
interface fifo_flow_ctrl_if
  import fifo_flow_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              fifo_empty;
  logic              fifo_full;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              error_ovf;
  logic              error_udf;

  modport master (
    output push, pop, data_in,
    input  data_out, valid_out, fifo_empty, fifo_full, almost_full,
           almost_empty, count, error_ovf, error_udf
  );

  modport slave (
    input  push, pop, data_in,
    output data_out, valid_out, fifo_empty, fifo_full, almost_full,
           almost_empty, count, error_ovf, error_udf
  );

endinterface : fifo_flow_ctrl_if

// File: rtl/fifo_flow_ctrl_memoria_fifo.sv
// -----------------------------------------------------------------------------
// memoria_fifo
// 2**ADDR_W x DATA_W register array for the lane FIFO.
//   clk      rising-edge clock
//   wr_en    write wr_data into mem[wr_addr] at the clock edge
//   wr_addr  write address
//   wr_data  write payload
//   rd_addr  read address (combinational read)
//   rd_data  mem[rd_addr]
// The array has no reset: a FIFO reset only clears the pointers, so stale
// contents are never observable.
// -----------------------------------------------------------------------------
module memoria_fifo #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The output register lives in the controller, so the read here is plain.
  assign rd_data = mem[rd_addr];

endmodule : memoria_fifo

// File: rtl/fifo_flow_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_flow_ctrl
// Single-clock circular FIFO serving one lane's arbiter push/pop strobes.
//   clk       rising-edge clock
//   reset_L   synchronous reset, active-low
//   bus       fifo_flow_ctrl_if.slave:
//               push/pop/data_in in; data_out + valid_out (registered, one
//               cycle after an accepted pop); fifo_empty, fifo_full,
//               almost_full, almost_empty, count; sticky error_ovf/error_udf
// Owns the pointers, occupancy count, status decodes, error flags and the
// data_out register; storage is in memoria_fifo.
// -----------------------------------------------------------------------------
module fifo_flow_ctrl
  import fifo_flow_ctrl_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic               clk,
  input  logic               reset_L,
  fifo_flow_ctrl_if.slave    bus
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              error_ovf_q, error_ovf_d;
  logic              error_udf_q, error_udf_d;

  logic              is_empty;
  logic              is_full;
  logic              push_ok;
  logic              pop_ok;
  logic [DATA_W-1:0] rd_data;

  // Status is a decode of the registered count, so it reflects an operation
  // the cycle after its clock edge.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_CNT);

  // Acceptance is judged against the pre-edge state: a pop on empty cannot
  // consume the word pushed in the same cycle, and a push on full cannot
  // take the slot freed by a same-cycle pop.
  assign push_ok = bus.push && !is_full;
  assign pop_ok  = bus.pop  && !is_empty;

  memoria_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    error_ovf_d = error_ovf_q;
    error_udf_d = error_udf_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end

    if (pop_ok) begin
      rd_ptr_d    = rd_ptr_q + ADDR_W'(1);
      data_out_d  = rd_data;
      valid_out_d = 1'b1;
    end

    // Both accepted leaves occupancy unchanged.
    if (push_ok && !pop_ok) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end

    if (bus.push && is_full) begin
      error_ovf_d = 1'b1;
    end
    if (bus.pop && is_empty) begin
      error_udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      error_ovf_q <= 1'b0;
      error_udf_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_ovf_q <= error_ovf_d;
      error_udf_q <= error_udf_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_out_q;
  assign bus.fifo_empty   = is_empty;
  assign bus.fifo_full    = is_full;
  assign bus.almost_full  = (count_q >= AF_CNT);
  assign bus.almost_empty = (count_q <= AE_CNT);
  assign bus.count        = count_q;
  assign bus.error_ovf    = error_ovf_q;
  assign bus.error_udf    = error_udf_q;

endmodule : fifo_flow_ctrl

// File: tb/tb_fifo_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_flow_ctrl
// Directed scenarios followed by random push/pop traffic, each cycle checked
// against a queue-based reference model of the lane FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_flow_ctrl;
  import fifo_flow_ctrl_pkg::*;

  localparam int DATA_W = DEF_DATA_W;
  localparam int ADDR_W = DEF_ADDR_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk;
  logic reset_L;

  fifo_flow_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fifo_flow_ctrl #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AF_THRESH (DEF_AF_THRESH),
    .AE_THRESH (DEF_AE_THRESH)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int unsigned model_q[$];
  int unsigned m_data_out;
  bit          m_valid;
  bit          m_ovf;
  bit          m_udf;

  int tests_run;
  int tests_failed;
  int step_no;

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s (step %0d): got 0x%0h expected 0x%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_all();
    int unsigned n;
    n = model_q.size();
    check_val("count",        32'(bus.count),        n);
    check_val("valid_out",    32'(bus.valid_out),    32'(m_valid));
    check_val("data_out",     32'(bus.data_out),     m_data_out);
    check_val("fifo_empty",   32'(bus.fifo_empty),   32'(n == 0));
    check_val("fifo_full",    32'(bus.fifo_full),    32'(n == DEPTH));
    check_val("almost_full",  32'(bus.almost_full),  32'(n >= DEF_AF_THRESH));
    check_val("almost_empty", 32'(bus.almost_empty), 32'(n <= DEF_AE_THRESH));
    check_val("error_ovf",    32'(bus.error_ovf),    32'(m_ovf));
    check_val("error_udf",    32'(bus.error_udf),    32'(m_udf));
  endtask

  // One clock: drive at negedge, let the edge happen, advance the model,
  // then check all outputs at the following negedge.
  task automatic step(input bit do_rst, input bit do_push, input bit do_pop,
                      input int unsigned din);
    int unsigned n;
    reset_L     = !do_rst;
    bus.push    = do_push;
    bus.pop     = do_pop;
    bus.data_in = DATA_W'(din);
    @(posedge clk);
    n = model_q.size();
    if (do_rst) begin
      model_q.delete();
      m_data_out = 0;
      m_valid    = 0;
      m_ovf      = 0;
      m_udf      = 0;
    end else begin
      if (do_push && n == DEPTH) m_ovf = 1;
      if (do_pop && n == 0)      m_udf = 1;
      if (do_pop && n > 0) begin
        m_data_out = model_q.pop_front();
        m_valid    = 1;
      end else begin
        m_valid = 0;
      end
      if (do_push && n < DEPTH) model_q.push_back(din & ((1 << DATA_W) - 1));
    end
    @(negedge clk);
    step_no++;
    $display("[TB] step %0d rst=%0b push=%0b pop=%0b din=0x%02h -> count=%0d valid=%0b dout=0x%02h",
             step_no, do_rst, do_push, do_pop, din & 8'h3F, bus.count, bus.valid_out, bus.data_out);
    check_all();
  endtask

  task automatic do_push(input int unsigned d);
    step(0, 1, 0, d);
  endtask

  task automatic do_pop();
    step(0, 0, 1, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
  endtask

  initial begin
    int unsigned fill_vals [4];
    int unsigned wrap_vals [3];
    fill_vals = '{32'h11, 32'h22, 32'h33, 32'h04};
    wrap_vals = '{32'h2A, 32'h15, 32'h3F};
    tests_run    = 0;
    tests_failed = 0;
    step_no      = 0;
    reset_L      = 1'b0;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.data_in  = '0;
    m_data_out   = 0;
    m_valid      = 0;
    m_ovf        = 0;
    m_udf        = 0;
    @(negedge clk);

    // Reset state
    do_reset();
    do_reset();

    // Fill then drain
    foreach (fill_vals[i]) do_push(fill_vals[i]);
    for (int i = 0; i < 4; i++) do_pop();
    // Idle after drain: valid drops, data_out holds
    step(0, 0, 0, 0);

    // Wrap: pointers run past the top of the array
    for (int i = 0; i < 3; i++) do_push($urandom & 32'h3F);
    for (int i = 0; i < 3; i++) do_pop();
    foreach (wrap_vals[i]) do_push(wrap_vals[i]);
    for (int i = 0; i < 3; i++) do_pop();

    // Simultaneous push+pop at count=2
    do_push(32'h01);
    do_push(32'h02);
    step(0, 1, 1, 32'h03);
    do_pop();
    do_pop();

    // Simultaneous push+pop at empty: pop rejected, underflow flagged
    do_reset();
    step(0, 1, 1, 32'h07);

    // Overflow at full, then push+pop at full
    do_push(32'h08);
    do_push(32'h09);
    do_push(32'h0A);
    do_push(32'h3F);
    step(0, 1, 1, 32'h3E);
    do_push(32'h3D);

    // Reset mid-operation with count=3
    do_reset();
    do_push(32'h10);
    do_push(32'h20);
    do_push(32'h30);
    do_reset();
    do_pop();
    do_reset();

    // Random traffic, occasional reset, biased to reach full and empty
    for (int i = 0; i < 400; i++) begin
      bit r, pu, po;
      int unsigned bias;
      bias = (i / 50) % 2;
      r  = ($urandom_range(0, 59) == 0);
      pu = ($urandom_range(0, 9) < (bias ? 7 : 3));
      po = ($urandom_range(0, 9) < (bias ? 3 : 7));
      step(r, pu, po, $urandom & 32'h3F);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fifo_flow_ctrl
